fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the single-cycle core's instruction memory. Owns the program counter, drives the memory's 8-bit byte address, and registers each returned 32-bit word into a one-entry output stage with a valid/ready handshake toward decode. Handles branch/jump redirects and halt detection.

## Interface

Parameters:
- `ADDR_W`, 8: byte-address width toward instruction memory.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 8'h00: PC loaded on reset; must be word-aligned.
- `HALT_INSN`, 32'h0000_0000: fetched word that stops sequencing.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_addr` output `ADDR_W`: byte address to instruction memory; always equals `pc`.
- `imem_rd` input `DATA_W`: combinational read data for `imem_addr`, same cycle.
- `insn` output `DATA_W`: registered instruction.
- `insn_pc` output `ADDR_W`: byte address `insn` was fetched from.
- `insn_valid` output 1: `insn`/`insn_pc` hold an undelivered instruction.
- `insn_ready` input 1: decode accepts; transfer when `insn_valid & insn_ready`.
- `redirect_valid` input 1: load new PC and flush.
- `redirect_pc` input `ADDR_W`: redirect target; bits [1:0] ignored (forced to 0).
- `halted` output 1: sequencer in HALT state.
- `perf_fetch` output 16: delivered-instruction count (see Configuration).
- `perf_stall` output 16: backpressure-cycle count (see Configuration).

## Operation

- States: FETCH, HALT.
- Output stage "free" when `!insn_valid | insn_ready`.
- FETCH, stage free, no redirect: if `imem_rd != HALT_INSN`, capture `insn <= imem_rd`, `insn_pc <= pc`, `insn_valid <= 1`, `pc <= pc + 4` (mod 2^`ADDR_W`, 8'hFC wraps to 8'h00). If `imem_rd == HALT_INSN`, word not delivered; `pc` holds at halt address; `insn_valid <= 0` (if current entry being consumed); go HALT.
- FETCH, stage not free: hold `pc`, `insn`, `insn_pc`, `insn_valid`; no capture (decode sees stable data).
- HALT: `pc` frozen; a pending `insn_valid` entry still drains normally; no new captures.
- Redirect (highest priority, any state): `pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`, `insn_valid <= 0` (pending entry discarded, even if `insn_ready` same cycle), state <= FETCH. No capture that cycle.
- `reset` overrides redirect.
- `halted = (state == HALT)`.

## Timing

- Reset values: `pc`/`imem_addr` = `RESET_PC`, `insn` = 0, `insn_pc` = 0, `insn_valid` = 0, `halted` = 0, state FETCH, perf counters 0.
- Latency: word at address P appears on `insn` with `insn_valid=1` one cycle after `pc == P` and stage free.
- Throughput: one instruction per cycle with `insn_ready` held high.
- After redirect in cycle N: `imem_addr` = target in N+1; target instruction valid in N+2.
- Halt: `halted` rises the cycle after `pc` addressed `HALT_INSN`.
- Reset mid-operation: all state returns to reset values next edge regardless of handshake.
- `insn_valid` never drops without a transfer except by redirect or reset.

## Configuration

- `FETCH_PERF_EN` defined: `perf_fetch` increments on each `insn_valid & insn_ready` transfer; `perf_stall` increments each cycle `insn_valid & !insn_ready`; both saturate at 16'hFFFF, clear on reset.
- Undefined: counter logic omitted; `perf_fetch` and `perf_stall` tied to 16'h0000.

## Test plan

- Reset, memory words 0x11,0x22,0x33 at 0x00/0x04/0x08, `insn_ready`=1 -> `insn` 0x11,0x22,0x33 on consecutive cycles from first cycle after reset, `insn_pc` 0x00,0x04,0x08.
- Hold `insn_ready`=0 for 3 cycles while `insn_valid` -> `insn`, `insn_pc`, `imem_addr` unchanged; with `FETCH_PERF_EN`, `perf_stall`=3, `perf_fetch` unchanged.
- `redirect_valid` with `redirect_pc`=8'h43 while entry pending -> pending entry dropped, `imem_addr`=8'h40 next cycle, word at 0x40 valid the cycle after.
- `HALT_INSN` at 0x0C -> instructions 0x00–0x08 delivered, `halted`=1, `imem_addr` stays 0x0C, `insn_valid`=0 after drain; redirect to 0x00 -> `halted`=0, fetch resumes.
- PC at 8'hFC, no halt -> next `imem_addr`=8'h00 (wrap); assert `reset` mid-stream with `insn_valid`=1 -> next cycle `insn_valid`=0, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and registers fetched words into a
// one-entry valid/ready stage. Optional perf counters are enabled by FETCH_PERF_EN.
`timescale 1ns/1ps
module fetch_sequencer #(
   parameter int                 ADDR_W    = 8,
   parameter int                 DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [DATA_W-1:0]  HALT_INSN = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rd,
   output logic [DATA_W-1:0] insn,
   output logic [ADDR_W-1:0] insn_pc,
   output logic              insn_valid,
   input  logic              insn_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic [15:0]       perf_fetch,
   output logic [15:0]       perf_stall
);

   typedef enum logic {S_FETCH, S_HALT} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_insn;
   logic [ADDR_W-1:0] r_insn_pc;
   logic              r_valid;

   logic              w_free;
   logic              w_is_halt;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_redirect_pc;

   assign w_free        = !r_valid || insn_ready;
   assign w_is_halt     = (imem_rd == HALT_INSN);
   assign w_pc_next     = r_pc + ADDR_W'(4);
   assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_insn    <= '0;
         r_insn_pc <= '0;
         r_valid   <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect flushes the pending entry even if decode is taking it now.
         r_state <= S_FETCH;
         r_pc    <= w_redirect_pc;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_free) begin
                  if (!w_is_halt) begin
                     r_insn    <= imem_rd;
                     r_insn_pc <= r_pc;
                     r_valid   <= 1'b1;
                     r_pc      <= w_pc_next;
                  end else begin
                     r_valid <= 1'b0;
                     r_state <= S_HALT;
                  end
               end
            end
            S_HALT: begin
               if (r_valid && insn_ready)
                  r_valid <= 1'b0;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] r_perf_fetch;
   logic [15:0] r_perf_stall;
   logic        w_xfer;
   logic        w_stall;

   assign w_xfer  = r_valid && insn_ready;
   assign w_stall = r_valid && !insn_ready;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_xfer && r_perf_fetch != 16'hFFFF)
            r_perf_fetch <= r_perf_fetch + 16'd1;
         if (w_stall && r_perf_stall != 16'hFFFF)
            r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_fetch = r_perf_fetch;
   assign perf_stall = r_perf_stall;
`else
   assign perf_fetch = 16'h0000;
   assign perf_stall = 16'h0000;
`endif

   assign imem_addr  = r_pc;
   assign insn       = r_insn;
   assign insn_pc    = r_insn_pc;
   assign insn_valid = r_valid;
   assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed test-plan scenarios then random
// traffic, checked against a cycle-level behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic [31:0] insn;
   logic [7:0]  insn_pc;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        halted;
   logic [15:0] perf_fetch;
   logic [15:0] perf_stall;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [0:63];
   assign imem_rd = mem[imem_addr[7:2]];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid), .insn_ready(insn_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
      .perf_fetch(perf_fetch), .perf_stall(perf_stall)
   );

   // Reference model state: what the sequencer registers should hold.
   logic [7:0]  m_pc, m_ipc;
   logic [31:0] m_insn;
   logic        m_valid, m_halt;
   int          m_pf, m_ps;
   logic [39:0] sbq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == 32'h0) w = 32'h1;
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      return w;
   endfunction

   task automatic model_step(input logic rdy, input logic rv, input logic [7:0] rpc, input logic rst);
      if (rst) begin
         m_pc = 8'h00; m_valid = 0; m_insn = 0; m_ipc = 0; m_halt = 0; m_pf = 0; m_ps = 0;
      end else begin
         if (m_valid && rdy && m_pf < 16'hFFFF) m_pf++;
         if (m_valid && !rdy && m_ps < 16'hFFFF) m_ps++;
         if (rv) begin
            m_pc = {rpc[7:2], 2'b00}; m_valid = 0; m_halt = 0;
         end else if (!m_halt && (!m_valid || rdy)) begin
            if (mem[m_pc >> 2] != 32'h0) begin
               m_insn = mem[m_pc >> 2]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 8'd4;
            end else begin
               m_valid = 0; m_halt = 1;
            end
         end else if (m_halt && m_valid && rdy) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc, input logic rst);
      insn_ready = rdy; redirect_valid = rv; redirect_pc = rpc; reset = rst;
      if (!rst && !rv && m_valid && rdy) sbq.push_back({m_ipc, m_insn});
      @(posedge clk);
      model_step(rdy, rv, rpc, rst);
      @(negedge clk);
      check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc});
      check("insn_valid", {31'h0, insn_valid}, {31'h0, m_valid});
      check("insn", insn, m_insn);
      check("insn_pc", {24'h0, insn_pc}, {24'h0, m_ipc});
      check("halted", {31'h0, halted}, {31'h0, m_halt});
`ifdef FETCH_PERF_EN
      check("perf_fetch", {16'h0, perf_fetch}, m_pf[31:0]);
      check("perf_stall", {16'h0, perf_stall}, m_ps[31:0]);
`else
      check("perf_fetch", {16'h0, perf_fetch}, 32'h0);
      check("perf_stall", {16'h0, perf_stall}, 32'h0);
`endif
   endtask

   // Monitor: every delivered instruction must match the next expected one.
   always @(posedge clk) begin
      if (insn_valid && insn_ready && !redirect_valid && !reset) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: got pc %h insn %h expected nothing", insn_pc, insn);
         end else begin
            logic [39:0] e;
            e = sbq.pop_front();
            if ({insn_pc, insn} !== e) begin
               fails++;
               $display("FAIL sb_xfer: got %h expected %h", {insn_pc, insn}, e);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = rand_word() | 32'h8000_0000;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      mem[16] = 32'hA5A5_0040; mem[63] = 32'hFF00_00FC;

      // Reset state.
      @(negedge clk);
      cycle(1, 0, 8'h00, 1);
      cycle(1, 0, 8'h00, 1);
      check("rst_addr", {24'h0, imem_addr}, 32'h0);
      check("rst_valid", {31'h0, insn_valid}, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);

      // Back-to-back delivery.
      cycle(1, 0, 8'h00, 0);
      check("seq0_insn", insn, 32'h11); check("seq0_pc", {24'h0, insn_pc}, 32'h00);
      cycle(1, 0, 8'h00, 0);
      check("seq1_insn", insn, 32'h22); check("seq1_pc", {24'h0, insn_pc}, 32'h04);
      cycle(1, 0, 8'h00, 0);
      check("seq2_insn", insn, 32'h33); check("seq2_pc", {24'h0, insn_pc}, 32'h08);

      // Backpressure holds everything.
      repeat (3) begin
         cycle(0, 0, 8'h00, 0);
         check("stall_insn", insn, 32'h33);
         check("stall_addr", {24'h0, imem_addr}, 32'h0C);
      end
`ifdef FETCH_PERF_EN
      check("stall_perf", {16'h0, perf_stall}, 32'd3);
      check("stall_fetch", {16'h0, perf_fetch}, 32'd2);
`endif

      // Redirect with unaligned target while an entry is pending.
      cycle(0, 1, 8'h43, 0);
      check("redir_valid", {31'h0, insn_valid}, 32'h0);
      check("redir_addr", {24'h0, imem_addr}, 32'h40);
      cycle(0, 0, 8'h00, 0);
      check("redir_insn", insn, 32'hA5A5_0040);
      check("redir_pc", {24'h0, insn_pc}, 32'h40);

      // Halt at 0x0C, then restart.
      mem[3] = 32'h0;
      cycle(1, 1, 8'h00, 0);
      repeat (5) cycle(1, 0, 8'h00, 0);
      check("halt_halted", {31'h0, halted}, 32'h1);
      check("halt_addr", {24'h0, imem_addr}, 32'h0C);
      check("halt_valid", {31'h0, insn_valid}, 32'h0);
      cycle(1, 1, 8'h00, 0);
      check("unhalt", {31'h0, halted}, 32'h0);
      cycle(1, 0, 8'h00, 0);
      check("resume_insn", insn, 32'h11);
      mem[3] = 32'h44;

      // PC wrap, then reset mid-stream with an entry pending.
      cycle(0, 1, 8'hFC, 0);
      check("wrap_pre", {24'h0, imem_addr}, 32'hFC);
      cycle(0, 0, 8'h00, 0);
      check("wrap_addr", {24'h0, imem_addr}, 32'h00);
      check("wrap_pc", {24'h0, insn_pc}, 32'hFC);
      cycle(0, 0, 8'h00, 1);
      check("midrst_valid", {31'h0, insn_valid}, 32'h0);
      check("midrst_addr", {24'h0, imem_addr}, 32'h00);

      // Random traffic with sparse halt words.
      for (int i = 0; i < 64; i++) mem[i] = rand_word();
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 0) for (int i = 0; i < 64; i++) mem[i] = rand_word();
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
               8'($urandom), $urandom_range(0, 199) == 0);
      end
      cycle(1, 0, 8'h00, 1);
      check("sb_drained", sbq.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
